// File: rtl/div_sequencer_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// start is sampled only while busy=0; done is a one-cycle pulse qualifying result.
interface div_sequencer_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start, funct3, data1, data2, flush,
    input  result, busy, done
  );

  modport slave (
    input  start, funct3, data1, data2, flush,
    output result, busy, done
  );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced without iterating.
module div_sequencer (
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic [1:0]  op;
  logic        sign1;
  logic        sign2;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;

  logic        signed_in;
  logic        accept;
  logic        div_zero;
  logic        overflow;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] trial;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] fin_quo;
  logic [31:0] fin_rem;

  logic [31:0] result_d;
  logic        busy_d;
  logic        done_d;
  logic [31:0] result_q;
  logic        busy_q;
  logic        done_q;

  assign signed_in = ~bus.funct3[0];
  assign accept    = (state == IDLE) && bus.start && bus.funct3[2] && !bus.flush;
  assign div_zero  = (bus.data2 == 32'd0);
  assign overflow  = signed_in && (bus.data1 == 32'h8000_0000) && (bus.data2 == 32'hFFFF_FFFF);
  assign abs1      = (signed_in && bus.data1[31]) ? (~bus.data1 + 32'd1) : bus.data1;
  assign abs2      = (signed_in && bus.data2[31]) ? (~bus.data2 + 32'd1) : bus.data2;

  // The shifted partial remainder is always below 2*divisor, so bit 32 of the
  // 33-bit difference is set exactly when the trial subtraction underflows.
  assign trial = {rem, quo[31]} - {1'b0, divisor};

  always_comb begin
    step_rem = {rem[30:0], quo[31]};
    step_quo = {quo[30:0], 1'b0};
    if (!trial[32]) begin
      step_rem = trial[31:0];
      step_quo = {quo[30:0], 1'b1};
    end
  end

  assign fin_quo = (!op[0] && (sign1 ^ sign2)) ? (~step_quo + 32'd1) : step_quo;
  assign fin_rem = (!op[0] && sign1) ? (~step_rem + 32'd1) : step_rem;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (div_zero || overflow) ? FINISH : DIVIDE;
      DIVIDE:  if (count == 5'd0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Output logic, evaluated against the state being entered
  always_comb begin
    result_d = result_q;
    busy_d   = (state_nxt != IDLE);
    done_d   = (state_nxt == FINISH);
    if (state_nxt == FINISH) begin
      if (state == IDLE) begin
        if (bus.funct3[1]) result_d = div_zero ? bus.data1 : 32'd0;
        else               result_d = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      end else begin
        result_d = op[1] ? fin_rem : fin_quo;
      end
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 5'd0;
      op      <= 2'd0;
      sign1   <= 1'b0;
      sign2   <= 1'b0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
    end else if (accept) begin
      count   <= 5'd31;
      op      <= bus.funct3[1:0];
      sign1   <= signed_in && bus.data1[31];
      sign2   <= signed_in && bus.data2[31];
      divisor <= abs2;
      rem     <= 32'd0;
      quo     <= abs1;
    end else if ((state == DIVIDE) && !bus.flush) begin
      rem   <= step_rem;
      quo   <= step_quo;
      count <= (count == 5'd0) ? 5'd0 : count - 5'd1;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic
// reference model of RISC-V M-extension division semantics.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dbg_state;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res;
  logic [2:0]  rf;
  logic [31:0] ra;
  logic [31:0] rb;

  div_sequencer_if bus();

  div_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [31:0] exp;
    int          lat;
    exp = model(f, a, b);
    lat = (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.data1  = a;
    bus.data2  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.data1 = $urandom;
    bus.data2 = $urandom;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check("busy", {31'd0, bus.busy}, 32'd1);
      if (c < lat) begin
        check("done_early", {31'd0, bus.done}, 32'd0);
      end else begin
        check("done", {31'd0, bus.done}, 32'd1);
        check("result", bus.result, exp);
      end
      if (noise && c < lat) begin
        bus.start  = ($urandom_range(0, 1) == 1);
        bus.funct3 = {1'b1, 2'($urandom_range(0, 3))};
        bus.data1  = $urandom;
        bus.data2  = $urandom_range(0, 3);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("done_after", {31'd0, bus.done}, 32'd0);
    check("result_hold", bus.result, exp);
    last_res = exp;
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.data1  = 32'd0;
    bus.data2  = 32'd0;
    last_res   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    // First request lands on the first edge after reset release
    reset = 1'b0;
    do_op(3'b101, 32'd100, 32'd7, 1'b0);
    do_op(3'b111, 32'd100, 32'd7, 1'b0);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'b100, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op(3'b100, 32'd5, 32'd0, 1'b0);
    do_op(3'b111, 32'd5, 32'd0, 1'b0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b110, 32'h8000_0001, 32'd0, 1'b0);

    // Non-divide funct3 must be ignored
    bus.start  = 1'b1;
    bus.funct3 = 3'b011;
    bus.data1  = 32'd50;
    bus.data2  = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("ign_busy", {31'd0, bus.busy}, 32'd0);
    check("ign_done", {31'd0, bus.done}, 32'd0);
    check("ign_result", bus.result, last_res);

    // Flush mid-divide, then immediate restart
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.data1  = 32'd1000;
    bus.data2  = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("fl_busy", {31'd0, bus.busy}, 32'd1);
      check("fl_done", {31'd0, bus.done}, 32'd0);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_busy_off", {31'd0, bus.busy}, 32'd0);
    check("fl_no_done", {31'd0, bus.done}, 32'd0);
    check("fl_result", bus.result, last_res);
    bus.flush = 1'b0;
    do_op(3'b100, 32'd1000, 32'd3, 1'b0);

    // Flush and start together in IDLE: request dropped
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = 3'b101;
    bus.data1  = 32'd9;
    bus.data2  = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("fs_busy", {31'd0, bus.busy}, 32'd0);
    check("fs_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("fs_busy2", {31'd0, bus.busy}, 32'd0);
    check("fs_result", bus.result, last_res);

    // Flush during FINISH still presents that cycle's DONE
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.data1  = 32'd5;
    bus.data2  = 32'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("ff_done", {31'd0, bus.done}, 32'd1);
    check("ff_result", bus.result, model(3'b100, 32'd5, 32'd0));
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("ff_busy_after", {31'd0, bus.busy}, 32'd0);
    check("ff_done_after", {31'd0, bus.done}, 32'd0);
    check("ff_result_hold", bus.result, 32'hFFFF_FFFF);
    last_res = 32'hFFFF_FFFF;

    // Reset in the middle of a divide
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.data1  = $urandom;
    bus.data2  = 32'd13;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_result", bus.result, 32'd0);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    last_res = 32'd0;

    // Randomized operations with START noise while busy
    for (int i = 0; i < 24; i++) begin
      rf = {1'b1, 2'($urandom_range(0, 3))};
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        4:       rb = ra >> $urandom_range(1, 31);
        default: rb = $urandom;
      endcase
      do_op(rf, ra, rb, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  EX-stage request; sampled only in IDLE.
REQ-005 FUNCT3  input  3  op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 DATA1  input  32  dividend (rs1).
REQ-007 DATA2  input  32  divisor (rs2).
REQ-008 FLUSH  input  1  pipeline flush (branch/interrupt); aborts any operation.
REQ-009 RESULT  output  32  registered quotient or remainder.
REQ-010 BUSY  output  1  stall request to pipeline; registered.
REQ-011 DONE  output  1  one-cycle result-valid pulse; registered.

Function
REQ-012 The block SHALL be an FSM with states IDLE, DIVIDE, FINISH, plus a 5-bit iteration counter.
REQ-013 In IDLE, START=1 with FUNCT3[2]=1 SHALL latch FUNCT3, DATA1 and DATA2; START with FUNCT3[2]=0 SHALL be ignored.
REQ-014 Signed ops (FUNCT3[0]=0) SHALL divide absolute values and record the sign of each operand at latch time.
REQ-015 If DATA2=0 on accept: the FSM SHALL go IDLE->FINISH; DIV/DIVU result 0xFFFFFFFF; REM/REMU result = DATA1.
REQ-016 If DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF: the FSM SHALL go IDLE->FINISH; DIV result 0x80000000; REM result 0.
REQ-017 Otherwise the FSM SHALL go IDLE->DIVIDE with the counter at 31.
REQ-018 DIVIDE SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first, for 32 cycles.
REQ-019 After the counter=0 step, DIVIDE SHALL go to FINISH.
REQ-020 On entering FINISH, the quotient SHALL be negated if the operand signs differ (signed ops only).
REQ-021 On entering FINISH, the remainder SHALL take the dividend's sign (signed ops only).
REQ-022 In FINISH, RESULT SHALL be loaded (quotient for FUNCT3[1]=0, remainder for FUNCT3[1]=1), and DONE=1 for exactly one cycle.
REQ-023 FINISH SHALL always return to IDLE on the next cycle.
REQ-024 BUSY SHALL be 1 in DIVIDE and FINISH and 0 in IDLE; DONE SHALL be 1 only in FINISH.
REQ-025 Latency, START sampled at edge T, normal path: BUSY=1 for cycles T+1..T+33; DONE=1 and RESULT valid in cycle T+33.
REQ-026 Latency, special cases (REQ-015/016): BUSY=1 and DONE=1 with RESULT valid in cycle T+1.
REQ-027 START asserted while BUSY=1 SHALL be ignored, with no effect on the operation in flight.
REQ-028 RESULT SHALL hold its value until the next FINISH or RESET.
REQ-029 FLUSH=1 in any state SHALL force IDLE on the next edge with BUSY=0, DONE=0, and RESULT unchanged.
REQ-030 FLUSH and START both 1 in IDLE: FLUSH SHALL win and the request SHALL be dropped.
REQ-031 FLUSH in FINISH: the DONE pulse of that cycle SHALL still be presented; the next state SHALL be IDLE.
REQ-032 Quotient/remainder arithmetic SHALL be unsigned 32-bit with a 33-bit partial-remainder subtract; no overflow beyond the REQ-016 case.

Reset
REQ-033 RESET=1 at a rising edge SHALL force IDLE, counter=0, RESULT=0, BUSY=0, DONE=0, from any state including mid-DIVIDE.
REQ-034 RESET SHALL take priority over FLUSH and START.
REQ-035 The first START SHALL be accepted in the first cycle after RESET deasserts.

Verification
REQ-036 DIVU 100/7, START at T -> BUSY=1 for T+1..T+33; DONE=1 at T+33 with RESULT=14; REMU with the same operands -> RESULT=2.
REQ-037 DIV 0xFFFFFFF9/2 -> RESULT=0xFFFFFFFD; REM with the same operands -> RESULT=0xFFFFFFFF; DIV 7/0xFFFFFFFE -> RESULT=0xFFFFFFFD.
REQ-038 DIV 5/0 -> DONE at T+1 with RESULT=0xFFFFFFFF; REMU 5/0 -> RESULT=5.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> RESULT=0x80000000 at T+1; REM with the same operands -> RESULT=0.
REQ-040 FLUSH at T+10 -> BUSY=0 at T+11 with no DONE; a new START at T+11 is accepted and completes normally at T+44.
REQ-041 RESET at T+5 of an operation -> all outputs 0 next cycle; START pulses during BUSY=1 produce no extra DONE.
